// File: rtl/escaner_teclado_matricial_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Holds the debounce FSM state encoding, the one-cold column drive
// patterns, the key-code width and the column rotation helper.
package escaner_teclado_matricial_pkg;

  // Debounce / press-tracking states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_DEB_RELEASE
  } estado_t;

  // Width of a key code: 4*row + column.
  localparam int KEY_W = 4;

  // Active-low one-cold column drive patterns (bit c = column c).
  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  // Next column drive pattern. Any illegal pattern falls back to column 0
  // so the drive can never get stuck with several columns low.
  function automatic logic [3:0] columna_siguiente(input logic [3:0] actual);
    logic [3:0] siguiente;
    case (actual)
      COL_0:   siguiente = COL_1;
      COL_1:   siguiente = COL_2;
      COL_2:   siguiente = COL_3;
      COL_3:   siguiente = COL_0;
      default: siguiente = COL_0;
    endcase
    return siguiente;
  endfunction

endpackage

// File: rtl/escaner_teclado_matricial_generador_tick.sv
// Parameterised tick generator: a counter running 0..DIV-1 that raises
// o_Tick for the single cycle in which the count equals DIV-1.
// Ports:
//   i_Reloj  - clock
//   i_Reset  - synchronous, active-high reset (count returns to 0)
//   o_Tick   - one-cycle pulse every DIV cycles
module generador_tick #(
  parameter int DIV = 4
) (
  input  logic i_Reloj,
  input  logic i_Reset,
  output logic o_Tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cuenta_q;
  logic [CNT_W-1:0] cuenta_d;

  // The count restarts from 0 after DIV-1, so it never overflows its width.
  always_comb begin
    cuenta_d = cuenta_q + 1'b1;
    if (cuenta_q == ULTIMO) begin
      cuenta_d = '0;
    end
  end

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign o_Tick = (cuenta_q == ULTIMO);

endmodule

// File: rtl/escaner_teclado_matricial.sv
// 4x4 matrix keypad scanner with ghost-key rejection and debouncing.
// Drives one column low at a time, samples the synchronised rows into a
// 16-bit scan bitmap, classifies each full scan and runs a debounce FSM
// that reports exactly one strobe per accepted press.
// Ports:
//   i_Reloj            - clock
//   i_Reset            - synchronous, active-high reset
//   i_Filas            - keypad rows, asynchronous, active-low
//   o_Columnas         - keypad columns, active-low one-cold
//   o_Tecla            - code of last accepted key (4*row + column)
//   o_Tecla_Valida     - one-cycle strobe on press acceptance
//   o_Tecla_Presionada - high from press acceptance to release acceptance
module escaner_teclado_matricial
  import escaner_teclado_matricial_pkg::*;
#(
  parameter int CLK_HZ         = 100000000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             i_Reloj,
  input  logic             i_Reset,
  input  logic [3:0]       i_Filas,
  output logic [3:0]       o_Columnas,
  output logic [KEY_W-1:0] o_Tecla,
  output logic             o_Tecla_Valida,
  output logic             o_Tecla_Presionada
);

  localparam int DIV   = CLK_HZ / SCAN_HZ;
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] DEB_N   = CNT_W'(DEBOUNCE_SCANS);

  logic tick;

  generador_tick #(
    .DIV (DIV)
  ) u_generador_tick (
    .i_Reloj (i_Reloj),
    .i_Reset (i_Reset),
    .o_Tick  (tick)
  );

  // Scanner state
  logic [3:0]  filas_meta_q, filas_meta_d;
  logic [3:0]  filas_sync_q, filas_sync_d;
  logic [3:0]  columnas_q, columnas_d;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [15:0] bitmap_q, bitmap_d;
  logic        clasificar_q, clasificar_d;

  // Debounce FSM state
  estado_t          estado_q, estado_d;
  logic [KEY_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] tecla_q, tecla_d;
  logic             valida_q, valida_d;
  logic             presionada_q, presionada_d;

  // Classifier results
  logic [4:0]       num_bits;
  logic [KEY_W-1:0] tecla_unica;
  logic             es_unica;
  logic [CNT_W-1:0] cnt_inc;

  // Two-flop synchroniser on the rows, then column sampling on each tick.
  // The bitmap is cleared in the cycle after end of scan, once the
  // classifier has consumed it; the next tick is at least DIV cycles away.
  always_comb begin
    filas_meta_d = i_Filas;
    filas_sync_d = filas_meta_q;
    columnas_d   = columnas_q;
    col_idx_d    = col_idx_q;
    bitmap_d     = bitmap_q;
    clasificar_d = 1'b0;
    if (clasificar_q) begin
      bitmap_d = '0;
    end
    if (tick) begin
      for (int r = 0; r < 4; r++) begin
        bitmap_d[{2'(r), col_idx_q}] = ~filas_sync_q[r];
      end
      col_idx_d    = col_idx_q + 2'd1;
      columnas_d   = columna_siguiente(columnas_q);
      clasificar_d = (col_idx_q == 2'd3);
    end
  end

  // Population count and position of the (last) set bit. Only the position
  // of a single set bit is meaningful; two or more keys count as no key.
  always_comb begin
    num_bits    = '0;
    tecla_unica = '0;
    for (int k = 0; k < 16; k++) begin
      if (bitmap_q[k]) begin
        num_bits    = num_bits + 5'd1;
        tecla_unica = KEY_W'(k);
      end
    end
    es_unica = (num_bits == 5'd1);
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Debounce FSM, advanced only in the classification cycle.
  always_comb begin
    estado_d     = estado_q;
    cand_d       = cand_q;
    cnt_d        = cnt_q;
    tecla_d      = tecla_q;
    valida_d     = 1'b0;
    presionada_d = presionada_q;
    if (clasificar_q) begin
      case (estado_q)
        ST_IDLE: begin
          if (es_unica) begin
            cand_d   = tecla_unica;
            cnt_d    = CNT_UNO;
            estado_d = ST_DEB_PRESS;
          end
        end
        ST_DEB_PRESS: begin
          if (es_unica && (tecla_unica == cand_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_N) begin
              estado_d     = ST_HELD;
              tecla_d      = cand_q;
              valida_d     = 1'b1;
              presionada_d = 1'b1;
            end
          end else if (es_unica) begin
            cand_d = tecla_unica;
            cnt_d  = CNT_UNO;
          end else begin
            cnt_d    = '0;
            estado_d = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!(es_unica && (tecla_unica == tecla_q))) begin
            cnt_d    = CNT_UNO;
            estado_d = ST_DEB_RELEASE;
          end
        end
        ST_DEB_RELEASE: begin
          // A different single key also counts as release: rolling to a
          // new key only starts its debounce once this key is released.
          if (es_unica && (tecla_unica == tecla_q)) begin
            estado_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= DEB_N) begin
              cnt_d        = '0;
              estado_d     = ST_IDLE;
              presionada_d = 1'b0;
            end
          end
        end
        default: begin
          cnt_d    = '0;
          estado_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_Reloj) begin
    if (i_Reset) begin
      filas_meta_q <= 4'hF;
      filas_sync_q <= 4'hF;
      columnas_q   <= COL_0;
      col_idx_q    <= '0;
      bitmap_q     <= '0;
      clasificar_q <= 1'b0;
      estado_q     <= ST_IDLE;
      cand_q       <= '0;
      cnt_q        <= '0;
      tecla_q      <= '0;
      valida_q     <= 1'b0;
      presionada_q <= 1'b0;
    end else begin
      filas_meta_q <= filas_meta_d;
      filas_sync_q <= filas_sync_d;
      columnas_q   <= columnas_d;
      col_idx_q    <= col_idx_d;
      bitmap_q     <= bitmap_d;
      clasificar_q <= clasificar_d;
      estado_q     <= estado_d;
      cand_q       <= cand_d;
      cnt_q        <= cnt_d;
      tecla_q      <= tecla_d;
      valida_q     <= valida_d;
      presionada_q <= presionada_d;
    end
  end

  assign o_Columnas         = columnas_q;
  assign o_Tecla            = tecla_q;
  assign o_Tecla_Valida     = valida_q;
  assign o_Tecla_Presionada = presionada_q;

endmodule

// File: tb/tb_escaner_teclado_matricial.sv
// Directed testbench for escaner_teclado_matricial with a small keypad
// model (row r pulled low while column c is low and key 4r+c is pressed).
// With DIV=4 a full scan takes 16 cycles; counting posedges from the last
// reset edge, scan k ends at cycle 16k and the FSM reacts at 16k+1.
module tb_escaner_teclado_matricial;

   logic        clock;
   logic        reset;
   logic [3:0]  filas;
   logic [3:0]  columnas;
   logic [3:0]  tecla;
   logic        teclaValida;
   logic        teclaPresionada;
   logic [15:0] keyMask;

   int checks;
   int failures;
   int cycle;
   int strobeCount;
   int strobeCycle;
   int strobeCode;
   int heldDrops;
   bit trackHeld;

   escaner_teclado_matricial #(
      .CLK_HZ         (16),
      .SCAN_HZ        (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .i_Reloj            (clock),
      .i_Reset            (reset),
      .i_Filas            (filas),
      .o_Columnas         (columnas),
      .o_Tecla            (tecla),
      .o_Tecla_Valida     (teclaValida),
      .o_Tecla_Presionada (teclaPresionada)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Keypad model: a pressed key shorts its row to its column.
   always_comb begin
      filas = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (keyMask[r*4 + c] && !columnas[c]) begin
               filas[r] = 1'b0;
            end
         end
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
      end
   endtask

   // Sets which keys are held down.
   task automatic applyStimulus(input logic [15:0] mask);
      keyMask = mask;
   endtask

   // One clock, sampled 1 time unit after the edge; records strobes.
   task automatic stepCycle();
      @(posedge clock);
      #1;
      cycle++;
      if (teclaValida === 1'b1) begin
         strobeCount++;
         strobeCycle = cycle;
         strobeCode  = int'(tecla);
      end
      if (trackHeld && (teclaPresionada !== 1'b1)) begin
         heldDrops++;
      end
   endtask

   task automatic stepN(input int n);
      repeat (n) stepCycle();
   endtask

   // Reset for one edge; that edge becomes cycle 0.
   task automatic resetDut();
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      @(negedge clock);
      reset = 1'b0;
      cycle = 0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_columnas"}, int'(columnas), 4'b1110);
      checkOutput({tag, "_tecla"}, int'(tecla), 0);
      checkOutput({tag, "_valida"}, int'(teclaValida), 0);
      checkOutput({tag, "_presionada"}, int'(teclaPresionada), 0);
   endtask

   initial begin
      logic [3:0] expCols;
      checks    = 0;
      failures  = 0;
      cycle     = 0;
      trackHeld = 1'b0;
      heldDrops = 0;
      reset     = 1'b1;
      applyStimulus(16'h0000);
      repeat (2) @(posedge clock);
      resetDut();
      checkResetValues("reset");

      // Idle scanning: column rotates every 4 cycles, nothing reported.
      strobeCount = 0;
      for (int i = 0; i < 64; i++) begin
         stepCycle();
         expCols = 4'b1111 ^ (4'b0001 << ((cycle / 4) % 4));
         checkOutput("idle_columnas", int'(columnas), int'(expCols));
      end
      checkOutput("idle_strobes", strobeCount, 0);
      checkOutput("idle_tecla", int'(tecla), 0);

      // Key 9 (row 2, column 1) from scan 5: strobe after scan 7 ends (112).
      strobeCount = 0;
      strobeCycle = -1;
      applyStimulus(16'h0200);
      stepN(49);
      checkOutput("press9_count", strobeCount, 1);
      checkOutput("press9_cycle", strobeCycle, 113);
      checkOutput("press9_code", strobeCode, 9);
      checkOutput("press9_presionada", int'(teclaPresionada), 1);
      trackHeld = 1'b1;
      stepN(111);
      trackHeld = 1'b0;
      checkOutput("hold9_drops", heldDrops, 0);
      checkOutput("hold9_count", strobeCount, 1);

      // Release at 224: three clean scans end at 272, drop at 273.
      strobeCount = 0;
      applyStimulus(16'h0000);
      stepN(48);
      checkOutput("rel9_still_held", int'(teclaPresionada), 1);
      stepCycle();
      checkOutput("rel9_dropped", int'(teclaPresionada), 0);
      checkOutput("rel9_tecla_kept", int'(tecla), 9);
      checkOutput("rel9_no_strobe", strobeCount, 0);
      stepN(15);

      // Bounce on key 5: 2 scans, 1 gap, 3 scans; single strobe at 385.
      strobeCount = 0;
      strobeCycle = -1;
      applyStimulus(16'h0020);
      stepN(32);
      applyStimulus(16'h0000);
      stepN(16);
      applyStimulus(16'h0020);
      stepN(49);
      checkOutput("bounce5_count", strobeCount, 1);
      checkOutput("bounce5_cycle", strobeCycle, 385);
      checkOutput("bounce5_code", strobeCode, 5);
      stepN(15);
      applyStimulus(16'h0000);
      stepN(64);
      checkOutput("bounce5_released", int'(teclaPresionada), 0);

      // Keys 0 and 15 together are ghost-rejected; then key 0 alone.
      strobeCount = 0;
      strobeCycle = -1;
      applyStimulus(16'h8001);
      stepN(96);
      checkOutput("multi_no_strobe", strobeCount, 0);
      checkOutput("multi_presionada", int'(teclaPresionada), 0);
      checkOutput("multi_tecla_kept", int'(tecla), 5);
      applyStimulus(16'h0001);
      stepN(49);
      checkOutput("key0_count", strobeCount, 1);
      checkOutput("key0_cycle", strobeCycle, 609);
      checkOutput("key0_code", strobeCode, 0);
      stepN(15);
      applyStimulus(16'h0000);
      stepN(64);

      // Key 6 reaches count 2 (after 721), then reset mid-scan at 730.
      strobeCount = 0;
      applyStimulus(16'h0040);
      stepN(42);
      checkOutput("pre_reset_columnas", int'(columnas), 4'b1011);
      checkOutput("pre_reset_no_strobe", strobeCount, 0);
      resetDut();
      checkResetValues("midreset");
      strobeCount = 0;
      strobeCycle = -1;
      stepN(48);
      checkOutput("after_reset_early", strobeCount, 0);
      stepCycle();
      checkOutput("after_reset_count", strobeCount, 1);
      checkOutput("after_reset_cycle", strobeCycle, 49);
      checkOutput("after_reset_code", strobeCode, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
